// File: rtl/cim_seq_pkg.sv
// Shared types and helpers for the CIM layer-chain sequencer.
package cim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTE   = 2'd1,
    WAIT_NEXT = 2'd2,
    FUNC      = 2'd3
  } layer_state_t;

  // Layer 0 can hold one image in its input token and another in its datapath,
  // so peak occupancy is num_layers+2; size the counter so that value fits.
  function automatic int inflight_w(input int num_layers);
    return $clog2(num_layers + 3);
  endfunction

endpackage

// File: rtl/cim_layer_slot.sv
// One layer of the chain: input token, layer FSM, registered start/func pulses.
// With SEQ_PERF_CNT_EN defined the slot also exposes a WAIT_NEXT flag.
//
// state     | meaning
// IDLE      | layer empty, waiting for its input token
// COMPUTE   | CIM array running, waiting for layer_done
// WAIT_NEXT | result held, waiting for the downstream buffer to be free
// FUNC      | function unit writing result onward, waiting for func_done
module cim_layer_slot
  import cim_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic set_tok,
  input  logic next_free,
  input  logic layer_done,
  input  logic func_done,
  output logic tok,
  output logic start,
  output logic func_start,
  output logic busy,
  output logic fire
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic waiting
`endif
);

  layer_state_t state, state_nxt;
  logic         tok_nxt;
  logic         start_nxt;
  logic         func_start_nxt;

  always_comb begin
    state_nxt      = state;
    tok_nxt        = tok | set_tok;
    start_nxt      = 1'b0;
    func_start_nxt = 1'b0;
    fire           = 1'b0;
    case (state)
      IDLE: begin
        if (tok) begin
          state_nxt = COMPUTE;
          tok_nxt   = set_tok;
          start_nxt = 1'b1;
        end
      end
      COMPUTE: begin
        if (layer_done) state_nxt = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        if (next_free) begin
          state_nxt      = FUNC;
          func_start_nxt = 1'b1;
        end
      end
      FUNC: begin
        if (func_done) begin
          state_nxt = IDLE;
          fire      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tok        <= 1'b0;
      start      <= 1'b0;
      func_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      tok        <= tok_nxt;
      start      <= start_nxt;
      func_start <= func_start_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef SEQ_PERF_CNT_EN
  assign waiting = (state == WAIT_NEXT);
`endif

endmodule

// File: rtl/cim_layer_sequencer.sv
// Handshake sequencer for a chain of CIM layers: image/result handshakes, counters.
// Defining SEQ_PERF_CNT_EN adds the o_stall_cycles performance counter.
module cim_layer_sequencer
  import cim_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 5,
  parameter int PIPELINED  = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_img_valid,
  output logic                                o_img_ready,
  output logic [NUM_LAYERS-1:0]               o_start,
  input  logic [NUM_LAYERS-1:0]               i_layer_done,
  output logic [NUM_LAYERS-1:0]               o_func_start,
  input  logic [NUM_LAYERS-1:0]               i_func_done,
  output logic                                o_result_valid,
  input  logic                                i_result_ready,
  output logic [NUM_LAYERS-1:0]               o_busy,
  output logic [inflight_w(NUM_LAYERS)-1:0]   o_in_flight,
  output logic [CNT_W-1:0]                    o_img_count
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                    o_stall_cycles
`endif
);

  logic [NUM_LAYERS-1:0] tok;
  logic [NUM_LAYERS-1:0] fire;
  logic [NUM_LAYERS-1:0] set_tok;
  logic [NUM_LAYERS-1:0] next_free;
  logic                  img_hs;
  logic                  res_hs;
`ifdef SEQ_PERF_CNT_EN
  logic [NUM_LAYERS-1:0] waiting;
`endif

  assign o_img_ready = !tok[0] && ((PIPELINED != 0) || (o_in_flight == '0));
  assign img_hs      = i_img_valid && o_img_ready;
  assign res_hs      = o_result_valid && i_result_ready;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    if (g == 0) begin : g_src
      assign set_tok[g] = img_hs;
    end else begin : g_src
      assign set_tok[g] = fire[g-1];
    end

    // The output slot is judged on registered o_result_valid, costing one
    // bubble when a result is consumed and the next is ready to move in.
    if (g == NUM_LAYERS - 1) begin : g_dst
      assign next_free[g] = !o_result_valid;
    end else begin : g_dst
      assign next_free[g] = !o_busy[g+1] && !tok[g+1];
    end

    cim_layer_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .set_tok    (set_tok[g]),
      .next_free  (next_free[g]),
      .layer_done (i_layer_done[g]),
      .func_done  (i_func_done[g]),
      .tok        (tok[g]),
      .start      (o_start[g]),
      .func_start (o_func_start[g]),
      .busy       (o_busy[g]),
      .fire       (fire[g])
`ifdef SEQ_PERF_CNT_EN
      ,
      .waiting    (waiting[g])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_result_valid <= 1'b0;
      o_in_flight    <= '0;
      o_img_count    <= '0;
    end else begin
      if (fire[NUM_LAYERS-1]) o_result_valid <= 1'b1;
      else if (res_hs)        o_result_valid <= 1'b0;

      case ({img_hs, res_hs})
        2'b10:   o_in_flight <= o_in_flight + 1'b1;
        2'b01:   o_in_flight <= o_in_flight - 1'b1;
        default: o_in_flight <= o_in_flight;
      endcase

      if (res_hs) o_img_count <= o_img_count + 1'b1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stall_cycles <= '0;
    end else if ((|waiting) && (o_stall_cycles != '1)) begin
      o_stall_cycles <= o_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cim_layer_sequencer.sv
// Bench for cim_layer_sequencer: vector table, pulse-order scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_cim_layer_sequencer;
  import cim_seq_pkg::*;

  localparam int N   = 5;
  localparam int CW  = 16;
  localparam int IFW = inflight_w(N);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // pipelined instance
  logic           rst, iv, rr, ir, rv;
  logic [N-1:0]   ld, fd, st, fs, busy, man_ld, man_fd;
  logic [IFW-1:0] inf;
  logic [CW-1:0]  cnt;
  // non-pipelined instance
  logic           np_rst, np_iv, np_rr, np_ir, np_rv;
  logic [N-1:0]   np_st, np_fs, np_busy;
  logic [IFW-1:0] np_inf;
  logic [CW-1:0]  np_cnt;
`ifdef SEQ_PERF_CNT_EN
  logic [CW-1:0]  stall, np_stall;
`endif

  logic         auto_en = 1'b0;
  logic         mon_en  = 1'b0;
  logic [N-1:0] a_ld [2] = '{default: '0};
  logic [N-1:0] a_fd [2] = '{default: '0};
  int           cd_l [2][N];
  int           cd_f [2][N];
  logic [N-1:0] s_v, f_v;

  assign ld = auto_en ? a_ld[0] : man_ld;
  assign fd = auto_en ? a_fd[0] : man_fd;

  cim_layer_sequencer #(.NUM_LAYERS(N), .PIPELINED(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_img_valid(iv), .o_img_ready(ir),
    .o_start(st), .i_layer_done(ld), .o_func_start(fs), .i_func_done(fd),
    .o_result_valid(rv), .i_result_ready(rr), .o_busy(busy),
    .o_in_flight(inf), .o_img_count(cnt)
`ifdef SEQ_PERF_CNT_EN
    , .o_stall_cycles(stall)
`endif
  );

  cim_layer_sequencer #(.NUM_LAYERS(N), .PIPELINED(0), .CNT_W(CW)) dut_np (
    .clk(clk), .rst(np_rst), .i_img_valid(np_iv), .o_img_ready(np_ir),
    .o_start(np_st), .i_layer_done(a_ld[1]), .o_func_start(np_fs), .i_func_done(a_fd[1]),
    .o_result_valid(np_rv), .i_result_ready(np_rr), .o_busy(np_busy),
    .o_in_flight(np_inf), .o_img_count(np_cnt)
`ifdef SEQ_PERF_CNT_EN
    , .o_stall_cycles(np_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Layer model: every start/func_start is answered by its done pulse 3 cycles later.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      s_v = (k == 0) ? st : np_st;
      f_v = (k == 0) ? fs : np_fs;
      a_ld[k] = '0;
      a_fd[k] = '0;
      for (int i = 0; i < N; i++) begin
        if ((k == 0 && rst) || (k == 1 && np_rst)) begin
          cd_l[k][i] = 0;
          cd_f[k][i] = 0;
        end else begin
          if (cd_l[k][i] > 0) begin
            cd_l[k][i]--;
            if (cd_l[k][i] == 0) a_ld[k][i] = 1'b1;
          end
          if (cd_f[k][i] > 0) begin
            cd_f[k][i]--;
            if (cd_f[k][i] == 0) a_fd[k][i] = 1'b1;
          end
          if (s_v[i]) cd_l[k][i] = 3;
          if (f_v[i]) cd_f[k][i] = 3;
        end
      end
    end
  end

  // Scoreboard of expected pulse order: code i = o_start[i], 100+i = o_func_start[i].
  int exp_q[$];

  task automatic mon_pop(input int code);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL pulse_order: got unexpected pulse code %0d, expected none", code);
    end else begin
      e = exp_q.pop_front();
      check("pulse_order", code, e);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        if (st[i]) mon_pop(i);
        if (fs[i]) mon_pop(100 + i);
      end
    end
  end

  typedef struct {
    logic         rst, iv, rr;
    logic [N-1:0] ld, fd;
    logic         ir;
    logic [N-1:0] st, fs, busy;
    logic         rv;
    int           inf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic [N-1:0] l,
                              input logic [N-1:0] f, input logic e_ir,
                              input logic [N-1:0] e_st, input logic [N-1:0] e_fs,
                              input logic [N-1:0] e_busy, input int e_inf);
    vec_t x;
    x.rst = r; x.iv = v; x.rr = 1'b0; x.ld = l; x.fd = f;
    x.ir = e_ir; x.st = e_st; x.fs = e_fs; x.busy = e_busy; x.rv = 1'b0; x.inf = e_inf;
    return x;
  endfunction

  localparam int NV = 22;
  vec_t tv [NV];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t, acc, saw_low, n, hs_cnt, res_n, start2_n, leak, s0_cnt;
    logic [CW-1:0] s1;

    //          rst  iv  ld        fd        ir  st        fs        busy      inf
    tv[0]  = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 0);
    tv[1]  = mk(0,   1,  5'b00000, 5'b00000, 0,  5'b00000, 5'b00000, 5'b00000, 1);
    tv[2]  = mk(0,   0,  5'b00100, 5'b00000, 1,  5'b00001, 5'b00000, 5'b00001, 1);
    tv[3]  = mk(0,   0,  5'b00001, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00001, 1);
    tv[4]  = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00000, 5'b00001, 5'b00001, 1);
    tv[5]  = mk(0,   0,  5'b00000, 5'b00001, 1,  5'b00000, 5'b00000, 5'b00000, 1);
    tv[6]  = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00010, 5'b00000, 5'b00010, 1);
    tv[7]  = mk(0,   0,  5'b00000, 5'b00010, 1,  5'b00000, 5'b00000, 5'b00010, 1);
    tv[8]  = mk(0,   0,  5'b00010, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00010, 1);
    tv[9]  = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00000, 5'b00010, 5'b00010, 1);
    tv[10] = mk(0,   0,  5'b00000, 5'b00010, 1,  5'b00000, 5'b00000, 5'b00000, 1);
    tv[11] = mk(0,   1,  5'b00000, 5'b00000, 0,  5'b00100, 5'b00000, 5'b00100, 2);
    tv[12] = mk(0,   0,  5'b00100, 5'b00000, 1,  5'b00001, 5'b00000, 5'b00101, 2);
    tv[13] = mk(0,   0,  5'b00001, 5'b00000, 1,  5'b00000, 5'b00100, 5'b00101, 2);
    tv[14] = mk(0,   0,  5'b00000, 5'b00100, 1,  5'b00000, 5'b00001, 5'b00001, 2);
    tv[15] = mk(0,   0,  5'b00000, 5'b00001, 1,  5'b01000, 5'b00000, 5'b01000, 2);
    tv[16] = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00010, 5'b00000, 5'b01010, 2);
    tv[17] = mk(0,   0,  5'b00010, 5'b00000, 1,  5'b00000, 5'b00000, 5'b01010, 2);
    tv[18] = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00000, 5'b00010, 5'b01010, 2);
    tv[19] = mk(1,   0,  5'b00000, 5'b00010, 1,  5'b00000, 5'b00000, 5'b00000, 0);
    tv[20] = mk(0,   0,  5'b01000, 5'b00010, 1,  5'b00000, 5'b00000, 5'b00000, 0);
    tv[21] = mk(0,   0,  5'b00000, 5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 0);

    rst = 1'b1; iv = 1'b0; rr = 1'b0; man_ld = '0; man_fd = '0;
    np_rst = 1'b1; np_iv = 1'b0; np_rr = 1'b0;
    repeat (3) @(negedge clk);

    // Table: one image walked by hand, a second image, spurious dones, reset mid-flight.
    for (int v = 0; v < NV; v++) begin
      rst = tv[v].rst; iv = tv[v].iv; rr = tv[v].rr;
      man_ld = tv[v].ld; man_fd = tv[v].fd;
      @(negedge clk);
      check($sformatf("vec%0d_img_ready", v), ir, tv[v].ir);
      check($sformatf("vec%0d_start", v), st, tv[v].st);
      check($sformatf("vec%0d_func_start", v), fs, tv[v].fs);
      check($sformatf("vec%0d_busy", v), busy, tv[v].busy);
      check($sformatf("vec%0d_result_valid", v), rv, tv[v].rv);
      check($sformatf("vec%0d_in_flight", v), inf, tv[v].inf);
    end
    check("vec_img_count", cnt, 0);
    man_ld = '0; man_fd = '0;

    // Single image through all layers, pulse order scoreboarded.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    auto_en = 1'b1; mon_en = 1'b1;
    check("t1_ready_at_start", ir, 1);
    for (int i = 0; i < N; i++) begin
      exp_q.push_back(i);
      exp_q.push_back(100 + i);
    end
    iv = 1'b1; @(negedge clk); iv = 1'b0;
    t = 0;
    while (!rv && t < 300) begin @(negedge clk); t++; end
    check("t1_result_valid", rv, 1);
    check("t1_pulses_left", exp_q.size(), 0);
    check("t1_in_flight_held", inf, 1);
    check("t1_count_before", cnt, 0);
    rr = 1'b1; @(negedge clk); rr = 1'b0;
    check("t1_result_cleared", rv, 0);
    check("t1_img_count", cnt, 1);
    check("t1_in_flight_zero", inf, 0);
    check("t1_busy_zero", busy, 0);
    mon_en = 1'b0;

    // Six images offered back to back, consumer stalled.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    acc = 0; saw_low = 0; t = 0;
    while (acc < 6 && t < 500) begin
      iv = 1'b1;
      if (ir) acc++;
      else if (acc > 0) saw_low = 1;
      @(negedge clk); t++;
    end
    iv = 1'b0;
    check("t2_accepted", acc, 6);
    check("t2_ready_fell", saw_low, 1);
    repeat (150) @(negedge clk);
    check("t2_in_flight", inf, 6);
    check("t2_result_valid", rv, 1);
    check("t2_layer4_busy", busy[4], 1);
    check("t2_img_count", cnt, 0);
`ifdef SEQ_PERF_CNT_EN
    s1 = stall;
    @(negedge clk);
    check("t2_stall_step1", stall, s1 + 1);
    repeat (5) @(negedge clk);
    check("t2_stall_step6", stall, s1 + 6);
`else
    s1 = '0;
`endif

    // Simultaneous image accept and result handshake at in_flight=3.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    check("t4_stall_reset", stall, 0);
`endif
    acc = 0; t = 0;
    while (acc < 3 && t < 300) begin
      iv = 1'b1;
      if (ir) acc++;
      @(negedge clk); t++;
    end
    iv = 1'b0;
    repeat (150) @(negedge clk);
    check("t4_in_flight_pre", inf, 3);
    check("t4_result_valid_pre", rv, 1);
    check("t4_ready", ir, 1);
    iv = 1'b1; rr = 1'b1; @(negedge clk); iv = 1'b0; rr = 1'b0;
    check("t4_in_flight_same", inf, 3);
    check("t4_img_count", cnt, 1);
    check("t4_result_cleared", rv, 0);
    rr = 1'b1; t = 0;
    while (inf != 0 && t < 400) begin @(negedge clk); t++; end
    rr = 1'b0;
    check("t4_drained", inf, 0);
    check("t4_img_count_final", cnt, 4);

    // Non-pipelined instance: no second accept until the result handshake.
    np_rst = 1'b0; np_iv = 1'b1; np_rr = 1'b1;
    hs_cnt = 0; res_n = -1; start2_n = -1; leak = 0; s0_cnt = 0; n = 0;
    while (start2_n < 0 && n < 400) begin
      if (hs_cnt >= 1 && res_n < 0 && np_ir) leak = 1;
      if (np_rv && np_rr && res_n < 0) res_n = n;
      if (np_st[0]) begin
        s0_cnt++;
        if (s0_cnt == 2) start2_n = n;
      end
      if (np_iv && np_ir) hs_cnt++;
      if (start2_n < 0) begin @(negedge clk); n++; end
    end
    check("t3_second_start_seen", (start2_n >= 0), 1);
    check("t3_ready_held_low", leak, 0);
    check("t3_restart_gap", start2_n - res_n, 3);
    check("t3_img_count", np_cnt, 1);
    check("t3_in_flight", np_inf, 1);
    check("t3_layer0_busy", np_busy[0], 1);
`ifdef SEQ_PERF_CNT_EN
    check("t3_stall_nonzero", (np_stall != 0), 1);
`endif
    np_iv = 1'b0; np_rr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
